uart_host_bridge: RTL and testbench

- Register-mapped host front end for the existing 8-bit UART byte interface.
- Connects the CPU-side bus (one-cycle access strobes) to the UART's transmit/tx_byte/is_transmitting and received/rx_byte/recv_error signals.
- Buffers received bytes in an RX FIFO and queued writes in a TX FIFO; a launch FSM feeds the UART one byte per frame.
- Provides sticky error flags, a status register and a level interrupt.

---
 rtl/uart_host_bridge_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_host_bridge.sv | 192 +++++++++++++++++++
 tb/tb_uart_host_bridge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_host_bridge_pkg.sv
// Shared constants for the UART host bridge: register addresses, status and
// control bit positions, and the TX launch FSM encoding.
package uart_host_bridge_pkg;

   // Register map
   localparam logic ADDR_STATUS = 1'b0;
   localparam logic ADDR_DATA   = 1'b1;

   // Status register bit positions
   localparam int unsigned STAT_RDRF = 0;
   localparam int unsigned STAT_TDRE = 1;
   localparam int unsigned STAT_OVR  = 2;
   localparam int unsigned STAT_FE   = 3;
   localparam int unsigned STAT_BUSY = 4;
   localparam int unsigned STAT_IRQ  = 7;

   // Control register bit positions
   localparam int unsigned CTRL_RXIE = 0;
   localparam int unsigned CTRL_TXIE = 1;
   localparam int unsigned CTRL_LOOP = 2;
   localparam int unsigned CTRL_CLR  = 7;

   // TX launch FSM encodings, kept bit-compatible with the legacy design
   localparam logic [1:0] TX_ST_IDLE      = 2'd0;
   localparam logic [1:0] TX_ST_LAUNCH    = 2'd1;
   localparam logic [1:0] TX_ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] TX_ST_WAIT_DONE = 2'd3;

   typedef enum logic [1:0] {
      TX_IDLE      = TX_ST_IDLE,
      TX_LAUNCH    = TX_ST_LAUNCH,
      TX_WAIT_BUSY = TX_ST_WAIT_BUSY,
      TX_WAIT_DONE = TX_ST_WAIT_DONE
   } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth. A push on a full FIFO is accepted
// only when a pop happens in the same cycle; pops on an empty FIFO are ignored.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // Accept/reject decisions and next pointer/count values
   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   // Storage array; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_host_bridge.sv
// Register-mapped host front end for the 8-bit UART byte interface.
// RX/TX FIFOs, launch FSM, sticky OVR/FE flags, status register and irq.
// Optional loopback (control bit2) built only with UART_HOST_BRIDGE_LOOPBACK_EN.
module uart_host_bridge
   import uart_host_bridge_pkg::*;
#(
   parameter int unsigned RX_DEPTH = 16,
   parameter int unsigned TX_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       we,
   input  logic       addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       irq,
   output logic       uart_transmit,
   output logic [7:0] uart_tx_byte,
   input  logic       uart_is_transmitting,
   input  logic       uart_received,
   input  logic [7:0] uart_rx_byte,
   input  logic       uart_recv_error
);

   localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
   localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;

   logic             rd_stat, rd_data, wr_ctrl, wr_data;
   logic             rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]       rx_din, rx_head;
   logic [RX_CW-1:0] rx_count;
   logic             tx_pop, tx_full, tx_empty;
   logic [7:0]       tx_head;
   logic [TX_CW-1:0] tx_count;
   logic             loop_en, loop_push, ovr_set, clr, busy;
   logic [7:0]       status;

   tx_state_e  state_q, state_d;
   logic [7:0] tx_byte_q, tx_byte_d;
   logic [7:0] rdata_q, rdata_d;
   logic       irq_q, irq_d;
   logic       rxie_q, rxie_d, txie_q, txie_d;
   logic       ovr_q, ovr_d, fe_q, fe_d;

   assign rd_stat = cs & ~we & (addr == ADDR_STATUS);
   assign rd_data = cs & ~we & (addr == ADDR_DATA);
   assign wr_ctrl = cs &  we & (addr == ADDR_STATUS);
   assign wr_data = cs &  we & (addr == ADDR_DATA);

`ifdef UART_HOST_BRIDGE_LOOPBACK_EN
   logic loop_q, loop_d;

   // Loopback enable is a stored control bit
   always_comb begin
      loop_d = wr_ctrl ? wdata[CTRL_LOOP] : loop_q;
   end

   // Loopback enable register
   always_ff @(posedge clk) begin
      if (rst) begin
         loop_q <= 1'b0;
      end else begin
         loop_q <= loop_d;
      end
   end

   assign loop_en = loop_q;
`else
   assign loop_en = 1'b0;
`endif

   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (rx_din),
      .rdata (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_data),
      .pop   (tx_pop),
      .wdata (wdata),
      .rdata (tx_head),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   // TX launch FSM: one UART frame per popped byte, or direct RX push in loopback
   always_comb begin
      state_d   = state_q;
      tx_byte_d = tx_byte_q;
      tx_pop    = 1'b0;
      loop_push = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (!tx_empty) begin
               if (loop_en) begin
                  tx_pop    = 1'b1;
                  loop_push = 1'b1;
               end else if (!uart_is_transmitting) begin
                  tx_pop    = 1'b1;
                  tx_byte_d = tx_head;
                  state_d   = TX_LAUNCH;
               end
            end
         end
         TX_LAUNCH:    state_d = TX_WAIT_BUSY;
         TX_WAIT_BUSY: if (uart_is_transmitting)  state_d = TX_WAIT_DONE;
         TX_WAIT_DONE: if (!uart_is_transmitting) state_d = TX_IDLE;
         default:      state_d = TX_IDLE;
      endcase
   end

   // RX push source selection and overrun detection; the FIFO itself drops
   // a push on full unless the host pops in the same cycle
   always_comb begin
      rx_push = loop_push | (uart_received & ~loop_en);
      rx_din  = loop_push ? tx_head : uart_rx_byte;
      rx_pop  = rd_data & ~rx_empty;
      ovr_set = rx_push & rx_full & ~rx_pop;
   end

   // Control register, sticky flags (set beats clear), status, irq and read data
   always_comb begin
      clr    = wr_ctrl & wdata[CTRL_CLR];
      rxie_d = wr_ctrl ? wdata[CTRL_RXIE] : rxie_q;
      txie_d = wr_ctrl ? wdata[CTRL_TXIE] : txie_q;
      ovr_d  = ovr_set | (ovr_q & ~clr);
      fe_d   = uart_recv_error | (fe_q & ~clr);
      busy   = ~tx_empty | (state_q != TX_IDLE) | uart_is_transmitting;

      status            = '0;
      status[STAT_RDRF] = ~rx_empty;
      status[STAT_TDRE] = ~tx_full;
      status[STAT_OVR]  = ovr_q;
      status[STAT_FE]   = fe_q;
      status[STAT_BUSY] = busy;
      status[STAT_IRQ]  = irq_q;

      irq_d = (rxie_q & (~rx_empty | ovr_q | fe_q)) |
              (txie_q & tx_empty & (state_q == TX_IDLE) & ~uart_is_transmitting);

      rdata_d = rdata_q;
      if (rd_stat) begin
         rdata_d = status;
      end else if (rd_data) begin
         rdata_d = rx_empty ? 8'h00 : rx_head;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= TX_IDLE;
         tx_byte_q <= '0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
         rxie_q    <= 1'b0;
         txie_q    <= 1'b0;
         ovr_q     <= 1'b0;
         fe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_byte_q <= tx_byte_d;
         rdata_q   <= rdata_d;
         irq_q     <= irq_d;
         rxie_q    <= rxie_d;
         txie_q    <= txie_d;
         ovr_q     <= ovr_d;
         fe_q      <= fe_d;
      end
   end

   // FIFO occupancy can never exceed its depth
   assert property (@(posedge clk) disable iff (rst)
      (rx_count <= RX_CW'(RX_DEPTH)) && (tx_count <= TX_CW'(TX_DEPTH)));

   assign rdata         = rdata_q;
   assign irq           = irq_q;
   assign uart_transmit = (state_q == TX_LAUNCH);
   assign uart_tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_host_bridge.sv
// Scoreboard bench for uart_host_bridge: stimulus queues expected read data
// and expected launched bytes; monitors compare when the DUT presents them.
module tb_uart_host_bridge;

   localparam int FRAME = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cs = 1'b0, we = 1'b0, addr = 1'b0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata;
   logic       irq, uart_transmit;
   logic [7:0] uart_tx_byte;
   logic       uart_is_transmitting;
   logic       uart_received = 1'b0;
   logic [7:0] uart_rx_byte = '0;
   logic       uart_recv_error = 1'b0;
   logic       busy_model = 1'b0, busy_hold = 1'b0;

   int total = 0;
   int bad   = 0;

   logic [7:0] rd_exp[$];
   string      rd_name[$];
   logic [7:0] tx_exp[$];
   logic       rd_seen = 1'b0;
   logic       fell_since = 1'b1;
   logic       busy_prev = 1'b0;

   assign uart_is_transmitting = busy_model | busy_hold;

   always #5 clk = ~clk;

   uart_host_bridge #(.RX_DEPTH(16), .TX_DEPTH(4)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .cs                   (cs),
      .we                   (we),
      .addr                 (addr),
      .wdata                (wdata),
      .rdata                (rdata),
      .irq                  (irq),
      .uart_transmit        (uart_transmit),
      .uart_tx_byte         (uart_tx_byte),
      .uart_is_transmitting (uart_is_transmitting),
      .uart_received        (uart_received),
      .uart_rx_byte         (uart_rx_byte),
      .uart_recv_error      (uart_recv_error)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   // Simple UART transmitter model: busy one cycle after launch, FRAME cycles long
   initial begin
      forever begin
         @(negedge clk);
         if (uart_transmit && !rst) begin
            @(posedge clk); #1 busy_model = 1'b1;
            repeat (FRAME) @(posedge clk);
            #1 busy_model = 1'b0;
         end
      end
   end

   // Note every completed host read
   always @(posedge clk) rd_seen <= cs && !we && !rst;

   // Read-data monitor
   always @(negedge clk) begin
      if (rd_seen) begin
         if (rd_exp.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected: got 0x%02h expected no read", rdata);
         end else begin
            chk(rd_name.pop_front(), rdata, rd_exp.pop_front());
         end
      end
   end

   // Launch monitor: byte order and busy-fall between launches
   always @(negedge clk) begin
      if (busy_prev && !uart_is_transmitting) fell_since = 1'b1;
      busy_prev = uart_is_transmitting;
      if (uart_transmit) begin
         chk("tx_gap", {7'd0, fell_since}, 8'd1);
         fell_since = 1'b0;
         if (tx_exp.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected: got 0x%02h expected no launch", uart_tx_byte);
         end else begin
            chk("tx_byte", uart_tx_byte, tx_exp.pop_front());
         end
      end
   end

   task automatic wr(input logic a, input logic [7:0] d);
      @(posedge clk); #1 cs = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1 cs = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic a, input logic [7:0] exp, input string name);
      @(posedge clk); #1 cs = 1'b1; we = 1'b0; addr = a;
      rd_exp.push_back(exp); rd_name.push_back(name);
      @(posedge clk); #1 cs = 1'b0;
   endtask

   task automatic rx_inject(input logic [7:0] b);
      @(posedge clk); #1 uart_received = 1'b1; uart_rx_byte = b;
      @(posedge clk); #1 uart_received = 1'b0;
   endtask

   task automatic fe_pulse();
      @(posedge clk); #1 uart_recv_error = 1'b1;
      @(posedge clk); #1 uart_recv_error = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_irq", {7'd0, irq}, 8'h00);
      chk("rst_transmit", {7'd0, uart_transmit}, 8'h00);
      chk("rst_tx_byte", uart_tx_byte, 8'h00);
      @(posedge clk); #1 rst = 1'b0;

      // 1: two launches in order, BUSY while active
      tx_exp.push_back(8'h41); tx_exp.push_back(8'h42);
      wr(1'b1, 8'h41);
      wr(1'b1, 8'h42);
      rd(1'b0, 8'h12, "t1_status_busy");
      repeat (60) @(posedge clk);
      chk("t1_tx_drained", 8'(tx_exp.size()), 8'd0);
      rd(1'b0, 8'h02, "t1_status_idle");

      // 2: three received bytes, then empty read
      rx_inject(8'h10); rx_inject(8'h20); rx_inject(8'h30);
      rd(1'b1, 8'h10, "t2_rd0");
      rd(1'b1, 8'h20, "t2_rd1");
      rd(1'b1, 8'h30, "t2_rd2");
      rd(1'b1, 8'h00, "t2_rd_empty");
      rd(1'b0, 8'h02, "t2_status");

      // 3: overrun on 17th byte, first 16 intact, CLR
      for (int i = 0; i < 17; i++) rx_inject(8'(8'h80 + i));
      rd(1'b0, 8'h07, "t3_status_ovr");
      for (int i = 0; i < 16; i++) rd(1'b1, 8'(8'h80 + i), "t3_rd");
      rd(1'b0, 8'h06, "t3_status_drained");
      wr(1'b0, 8'h80);
      rd(1'b0, 8'h02, "t3_status_clr");

      // 4: full FIFO, same-cycle receive and read
      for (int i = 0; i < 16; i++) rx_inject(8'(8'h60 + i));
      @(posedge clk); #1 cs = 1'b1; we = 1'b0; addr = 1'b1;
      uart_received = 1'b1; uart_rx_byte = 8'h55;
      rd_exp.push_back(8'h60); rd_name.push_back("t4_rd_same");
      @(posedge clk); #1 cs = 1'b0; uart_received = 1'b0;
      rd(1'b0, 8'h03, "t4_status_no_ovr");
      for (int i = 1; i < 16; i++) rd(1'b1, 8'(8'h60 + i), "t4_rd");
      rd(1'b1, 8'h55, "t4_rd_last");
      rd(1'b1, 8'h00, "t4_rd_empty");

      // 5: FE interrupt with RXIE, CLR drops it; TXIE interrupt
      wr(1'b0, 8'h01);
      repeat (2) @(posedge clk); @(negedge clk);
      chk("t5_irq_idle", {7'd0, irq}, 8'h00);
      fe_pulse();
      @(negedge clk);
      chk("t5_irq_fe", {7'd0, irq}, 8'h01);
      rd(1'b0, 8'h8A, "t5_status_fe");
      wr(1'b0, 8'h81);
      repeat (2) @(posedge clk); @(negedge clk);
      chk("t5_irq_clr", {7'd0, irq}, 8'h00);
      rd(1'b0, 8'h02, "t5_status_clr");
      wr(1'b0, 8'h02);
      repeat (2) @(posedge clk);
      rd(1'b0, 8'h82, "t5_status_txie");
      wr(1'b0, 8'h00);

      // 6: TX overflow while UART busy, then reset mid-sequence
      @(posedge clk); #1 busy_hold = 1'b1;
      wr(1'b0, 8'h01);
      fe_pulse();
      for (int i = 0; i < 5; i++) wr(1'b1, 8'(8'hA1 + i));
      rd(1'b0, 8'h98, "t6_status_full");
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_rst_rdata", rdata, 8'h00);
      chk("t6_rst_irq", {7'd0, irq}, 8'h00);
      chk("t6_rst_transmit", {7'd0, uart_transmit}, 8'h00);
      chk("t6_rst_tx_byte", uart_tx_byte, 8'h00);
      @(posedge clk); #1 rst = 1'b0; busy_hold = 1'b0;
      repeat (5) @(posedge clk);
      rd(1'b0, 8'h02, "t6_status_after_rst");
      repeat (5) @(posedge clk);

      chk("end_rd_queue", 8'(rd_exp.size()), 8'd0);
      chk("end_tx_queue", 8'(tx_exp.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
